seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Upstream feeder for the 2-to-4 anode decoder on the 4-digit seven-segment scoreboard.
//  - Divides clk into a per-digit refresh tick and advances the 2-bit digit select en[1:0].
//  - Double-buffers a 4-digit BCD score, committing only at frame boundaries, so digits never tear.
//  - Drives the active-low cathodes for the digit currently selected.
// PARAMETERS
//  TICK_DIV  100_000  clk cycles per digit slot (>=2); 1 kHz/digit at 100 MHz
//  LZ_BLANK  1        1 = blank leading zeros on digits 3..1; 0 = show all digits
// PORTS
//  clk          in   1   system clock, single domain
//  reset        in   1   asynchronous, active-high reset
//  digits_in    in   16  BCD digits, [15:12]=digit3 (leftmost) .. [3:0]=digit0
//  load         in   1   1-cycle strobe: capture digits_in into the staging register
//  pending      out  1   staged value waiting for the next frame commit
//  en           out  2   digit select to the anode decoder; 0 = digit0 (AN0)
//  seg          out  7   cathodes {g,f,e,d,c,b,a}, active-low, for digit en
//  frame_start  out  1   1-cycle pulse on the edge where en wraps 3->0
// BEHAVIOUR
//  Reset (async, while high): prescaler=0, en=0, staging=0, display=0, pending=0,
//   frame_start=0, seg=7'b1000000 ("0" for digit0, never blanked).
//  Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle at TICK_DIV-1.
//  On tick: en <= en+1 mod 4. If en==3, frame_start is 1 for the following cycle only.
//  Load handshake:
//   - load=1 -> staging <= digits_in, pending <= 1.
//   - load while pending=1: staging is overwritten (latest wins), pending stays 1.
//  Commit: on tick with en==3, display <= staging and pending <= 0, unless load is also 1.
//  Load and commit in the same cycle: the commit takes the OLD staging value.
//   The new value is staged, and pending stays 1 until the next frame.
//  Timing: seg and en are both registered and updated on the same edge.
//   seg encodes display digit at the new en, so they never disagree for a cycle.
//   Commit and en 3->0 share an edge, so digit0 of the new frame shows the new data.
//  Decode:
//   - 0-9: standard patterns.
//   - Values 10-15: dash (7'b0111111, g only).
//   - Blank: 7'b1111111.
//  Leading-zero blanking (LZ_BLANK=1):
//   - digit k (k=3..1) blanks iff it and all digits above it are 0.
//   - digit0 always displays.
//   - Dashes (>9) are non-zero and stop blanking.
//  Latency: load to visible on digit0 is at most 4*TICK_DIV+1 cycles.
//  Reset mid-frame: immediate return to reset state; staged data is discarded.
//  Widths: prescaler width = $clog2(TICK_DIV). en is 2 bits and wraps naturally.
//  dp is not driven here; the anode decoder owns it.
// STRUCTURE
//  Shared package/header seg_pkg:
//   - SEG_0..SEG_9, SEG_DASH, SEG_BLANK constants.
//   - Cathode bit-order definition {g,f,e,d,c,b,a}.
//  Sub-module seg7_bcd_decode (combinational): 4-bit value + blank -> seg[6:0].
//  Top block contents: prescaler, en counter, staging/display registers, pending flag,
//   blanking logic, output registers.
// TESTING (bench uses TICK_DIV=4, LZ_BLANK=1 unless stated)
//  1 Reset released -> en=0, seg=7'b1000000, pending=0.
//    en steps 0,1,2,3,0 every 4 clks; frame_start pulses once per 16 clks.
//  2 load digits_in=16'h1234 mid-frame -> pending=1 next cycle.
//    At the en 3->0 edge, pending=0 and seg=SEG_4 on en=0, SEG_3/SEG_2/SEG_1 on en=1/2/3.
//  3 Display 16'h0005 -> en=3,2,1 give 7'b1111111; en=0 gives SEG_5.
//    Repeat with LZ_BLANK=0 -> SEG_0 on digits 3..1.
//  4 16'h0A07 -> digit3 blank, digit2 dash, digit1 SEG_0 (not blanked), digit0 SEG_7.
//  5 load 16'h1111 staged, then load 16'h2222 in the commit cycle -> frame shows 1111.
//    pending stays 1; the next frame shows 2222, then pending=0.
//  6 Assert reset while pending=1 and en=2 -> all outputs return to reset values immediately.
//    Staged data never appears on the display.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low cathode codes and the BCD lookup.
// Cathode bit order everywhere is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam int NUM_DIGITS = 4;

    // Non-BCD codes 10..15 show a dash so a corrupted score is visible.
    function automatic seg_t bcd_to_seg(input logic [3:0] value);
        seg_t result;
        case (value)
            4'd0:    result = SEG_0;
            4'd1:    result = SEG_1;
            4'd2:    result = SEG_2;
            4'd3:    result = SEG_3;
            4'd4:    result = SEG_4;
            4'd5:    result = SEG_5;
            4'd6:    result = SEG_6;
            4'd7:    result = SEG_7;
            4'd8:    result = SEG_8;
            4'd9:    result = SEG_9;
            default: result = SEG_DASH;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Score load / display scan bundle between the score source and the scan driver.
// master = score source side, slave = seg_scan_driver.
interface seg_scan_driver_if;
    import seg_pkg::*;

    logic [15:0] digits_in;
    logic        load;
    logic        pending;
    logic [1:0]  en;
    seg_t        seg;
    logic        frame_start;

    modport master (
        output digits_in,
        output load,
        input  pending,
        input  en,
        input  seg,
        input  frame_start
    );

    modport slave (
        input  digits_in,
        input  load,
        output pending,
        output en,
        output seg,
        output frame_start
    );

endinterface

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD digit to active-low seven-segment cathode pattern, with blanking.
module seg7_bcd_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : bcd_to_seg(value);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with a frame-synchronous
// double-buffered score so a digit update never tears across a refresh frame.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 100_000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    seg_scan_driver_if.slave   bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    en_q, en_d;
    logic [15:0]   staging_q, staging_d;
    logic [15:0]   display_q, display_d;
    logic          pending_q, pending_d;
    logic          frame_start_q, frame_start_d;
    seg_t          seg_q, seg_d;

    logic tick;
    logic commit;

    assign tick   = (presc_q == TICK_LAST);
    assign commit = tick && (en_q == 2'd3);

    always_comb begin
        presc_d       = tick ? '0 : presc_q + 1'b1;
        en_d          = tick ? en_q + 2'd1 : en_q;
        frame_start_d = commit;
        // A load coinciding with commit stages the new value; commit uses the old one.
        staging_d     = bus.load ? bus.digits_in : staging_q;
        display_d     = commit ? staging_q : display_q;
        pending_d     = pending_q;
        if (bus.load) begin
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
        end
    end

    // Blanking is derived from the next display value and next digit select so that
    // the registered seg always matches the registered en on the same edge.
    logic [3:0] digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] digit_nz;
    logic [NUM_DIGITS-1:0] lz_blank;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_val[gi] = display_d[4*gi +: 4];
        assign digit_nz[gi]  = |display_d[4*gi +: 4];
        if (gi == 0) begin : g_units
            assign lz_blank[gi] = 1'b0;
        end else if (gi == NUM_DIGITS - 1) begin : g_top
            assign lz_blank[gi] = LZ_BLANK && !digit_nz[gi];
        end else begin : g_mid
            assign lz_blank[gi] = lz_blank[gi+1] && !digit_nz[gi];
        end
    end

    seg7_bcd_decode u_decode (
        .value (digit_val[en_d]),
        .blank (lz_blank[en_d]),
        .seg   (seg_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            en_q          <= '0;
            staging_q     <= '0;
            display_q     <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_0;
        end else begin
            presc_q       <= presc_d;
            en_q          <= en_d;
            staging_q     <= staging_d;
            display_q     <= display_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
        end
    end

    assign bus.pending     = pending_q;
    assign bus.en          = en_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (leading-zero blanking on and off) share stimulus;
// expected frames are queued by the stimulus and checked slot by slot by a monitor.
module tb_seg_scan_driver;

    localparam int TD = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        string           name;
        logic [3:0][6:0] s1;
        logic [3:0][6:0] s0;
        logic            pend;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   frames_done = 0;
    frame_t exp_q[$];

    always #5 clk = ~clk;

    seg_scan_driver_if bus_a ();
    seg_scan_driver_if bus_b ();

    seg_scan_driver #(.TICK_DIV(TD), .LZ_BLANK(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    seg_scan_driver #(.TICK_DIV(TD), .LZ_BLANK(1'b0)) dut_nz (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic drive(input logic [15:0] d, input logic l);
        bus_a.digits_in = d;
        bus_b.digits_in = d;
        bus_a.load      = l;
        bus_b.load      = l;
    endtask

    task automatic push(input string n, input logic [27:0] a, input logic [27:0] b, input logic p);
        frame_t e;
        e.name = n;
        e.s1   = a;
        e.s0   = b;
        e.pend = p;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge of the first cycle of the next frame.
    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_a.frame_start !== 1'b1 && n < 100);
        if (bus_a.frame_start !== 1'b1) bound_fail("frame_start");
    endtask

    // Pulses load for the cycle that starts cyc rising edges from now.
    task automatic load_at(input int cyc, input logic [15:0] v);
        repeat (cyc) @(posedge clk);
        #1 drive(v, 1'b1);
        @(posedge clk);
        #1 drive(v, 1'b0);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (frames_done < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (frames_done < target) bound_fail("frame check");
    endtask

    // Monitor: on each frame start with an expectation queued, check all four digit slots.
    initial begin
        frame_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus_a.frame_start === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int s = 0; s < 4; s++) begin
                    if (s > 0) repeat (TD) @(negedge clk);
                    check({e.name, " en"}, 32'(bus_a.en), 32'(s));
                    check({e.name, " seg lz1"}, 32'(bus_a.seg), 32'(e.s1[s]));
                    check({e.name, " seg lz0"}, 32'(bus_b.seg), 32'(e.s0[s]));
                    if (s == 0) check({e.name, " pending"}, 32'(bus_a.pending), 32'(e.pend));
                end
                frames_done++;
                $display("frame %s checked (errors so far %0d)", e.name, errors);
            end
        end
    end

    initial begin
        int fs_count;
        drive(16'h0, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset en", 32'(bus_a.en), 0);
        check("reset seg", 32'(bus_a.seg), 32'(S0));
        check("reset seg lz0", 32'(bus_b.seg), 32'(S0));
        check("reset pending", 32'(bus_a.pending), 0);
        check("reset frame_start", 32'(bus_a.frame_start), 0);
        reset = 1'b0;
        $display("reset released");

        // Scan cadence: en steps every TD clocks, frame_start once per 4*TD clocks.
        fs_count = 0;
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            check("scan en", 32'(bus_a.en), 32'((i / TD) % 4));
            if (bus_a.frame_start === 1'b1) fs_count++;
        end
        check("frame_start count", 32'(fs_count), 2);
        $display("scan cadence: %0d frame_start pulses", fs_count);

        wait_frame();
        load_at(5, 16'h1234);
        @(negedge clk);
        check("pending after load", 32'(bus_a.pending), 1);
        push("1234", {S1, S2, S3, S4}, {S1, S2, S3, S4}, 1'b0);
        wait_done(1);

        wait_frame();
        load_at(3, 16'h0005);
        push("0005", {SB, SB, SB, S5}, {S0, S0, S0, S5}, 1'b0);
        wait_done(2);

        wait_frame();
        load_at(3, 16'h0A07);
        push("0A07", {SB, SD, S0, S7}, {S0, SD, S0, S7}, 1'b0);
        wait_done(3);

        // Second load lands in the commit cycle: old staging commits, new one stays pending.
        wait_frame();
        load_at(5, 16'h1111);
        push("1111", {S1, S1, S1, S1}, {S1, S1, S1, S1}, 1'b1);
        push("2222", {S2, S2, S2, S2}, {S2, S2, S2, S2}, 1'b0);
        load_at(9, 16'h2222);
        wait_done(5);

        // Asynchronous reset mid-frame discards staged data.
        wait_frame();
        load_at(2, 16'h9999);
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset en", 32'(bus_a.en), 2);
        check("pre-reset pending", 32'(bus_a.pending), 1);
        #2 reset = 1'b1;
        #1;
        check("async reset en", 32'(bus_a.en), 0);
        check("async reset seg", 32'(bus_a.seg), 32'(S0));
        check("async reset seg lz0", 32'(bus_b.seg), 32'(S0));
        check("async reset pending", 32'(bus_a.pending), 0);
        check("async reset frame_start", 32'(bus_a.frame_start), 0);
        $display("async reset applied mid-frame");
        @(posedge clk);
        #1 reset = 1'b0;
        push("post-reset", {SB, SB, SB, S0}, {S0, S0, S0, S0}, 1'b0);
        wait_done(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
